// File: rtl/pulse_train_gen.sv
// One-cycle strobe generator with a saturating backlog of requests and a forced
// low gap of MIN_GAP cycles after every pulse. state_dbg reads 0 only when IDLE.
module pulse_train_gen #(
  parameter int MIN_GAP = 1,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             clear,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [7:0]       GAP_LOAD = 8'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic             req_eff;
  logic             gap_last;
  logic             launch;
  logic             from_backlog;

  // A clear cycle swallows the request sampled alongside it.
  assign req_eff  = req_in & ~clear;
  assign gap_last = (gap_cnt_q == 8'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gap_cnt_q <= 8'd0;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    launch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_eff) begin
          state_d = PULSE;
          launch  = 1'b1;
        end
      end
      PULSE: begin
        state_d   = GAP;
        gap_cnt_d = GAP_LOAD;
      end
      GAP: begin
        if (!gap_last) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end else if (req_eff || ((|pend_q) && !clear)) begin
          state_d = PULSE;
          launch  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A launch out of GAP consumes one queued request; a same-cycle new request
  // replaces it, so the count is left alone in that case.
  assign from_backlog = launch && (state_q == GAP);

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clear) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (from_backlog) begin
      if (!req_in) pend_d = pend_q - PEND_ONE;
    end else if (req_in && (state_q != IDLE)) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + PEND_ONE;
    end
  end

  always_comb begin
    pulse_d   = (state_d == PULSE);
    pulse_out = pulse_q;
    pending   = pend_q;
    overflow  = ovf_q;
    busy      = (state_q != IDLE) || (|pend_q);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: four instances with different MIN_GAP/CNT_W share
// one stimulus stream and are checked every cycle against a timing-based model.
module tb_pulse_train_gen;

  localparam int N_DUT = 4;
  localparam int W     = 8;

  function automatic int mg_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int cw_of(input int i);
    case (i)
      0:       return 4;
      1:       return 2;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  logic clk;
  logic rst_n;
  logic req;
  logic clr;

  logic [N_DUT-1:0]      pulse_w;
  logic [N_DUT-1:0]      busy_w;
  logic [N_DUT-1:0]      ovf_w;
  logic [N_DUT-1:0][3:0] pend_w;
  logic [N_DUT-1:0][1:0] state_w;

  int tests_run = 0;
  int failures  = 0;

  logic [W-1:0] exp_q[$];
  int   cyc;
  int   m_pend [N_DUT];
  logic m_ovf  [N_DUT];
  int   m_last [N_DUT];
  int   pulse_cnt [N_DUT];
  int   since [N_DUT] = '{default: 1000};

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int MG = mg_of(g);
    localparam int CW = cw_of(g);
    logic [CW-1:0] pend;

    pulse_train_gen #(.MIN_GAP(MG), .CNT_W(CW)) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .req_in    (req),
      .clear     (clr),
      .pulse_out (pulse_w[g]),
      .pending   (pend),
      .busy      (busy_w[g]),
      .overflow  (ovf_w[g]),
      .state_dbg (state_w[g])
    );

    assign pend_w[g] = 4'(pend);

    a_no_back_to_back: assert property (@(posedge clk) disable iff (!rst_n)
      pulse_w[g] |-> !$past(pulse_w[g]))
      else begin
        failures++;
        $error("FAIL sva_back_to_back dut%0d observed=1 expected=0", g);
      end
  end

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Low-cycle count between pulses, watched on the falling edge.
  always @(negedge clk) begin
    for (int g = 0; g < N_DUT; g++) begin
      if (!rst_n) begin
        since[g] <= 1000;
      end else if (pulse_w[g]) begin
        tests_run++;
        assert (since[g] >= mg_of(g)) else begin
          failures++;
          $error("FAIL gap_len dut%0d observed=%0d expected>=%0d", g, since[g], mg_of(g));
        end
        since[g] <= 0;
      end else if (since[g] < 1000) begin
        since[g] <= since[g] + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int g = 0; g < N_DUT; g++) begin
      m_pend[g] = 0;
      m_ovf[g]  = 1'b0;
      m_last[g] = -1000;
    end
    exp_q.delete();
  endtask

  // A pulse may launch once MIN_GAP+1 edges have passed since the previous one;
  // inside that window requests only accumulate.
  task automatic model_edge(input logic r, input logic c);
    cyc++;
    for (int g = 0; g < N_DUT; g++) begin
      int   ri;
      int   maxp;
      logic active;
      logic pulse;
      logic busy_e;
      ri   = r ? 1 : 0;
      maxp = (1 << cw_of(g)) - 1;
      if (c) begin
        m_pend[g] = 0;
        m_ovf[g]  = 1'b0;
      end else if (cyc >= m_last[g] + mg_of(g) + 1) begin
        if (m_pend[g] + ri > 0) begin
          m_last[g] = cyc;
          m_pend[g] = m_pend[g] + ri - 1;
        end
      end else if (r) begin
        if (m_pend[g] == maxp) m_ovf[g] = 1'b1;
        else                   m_pend[g] = m_pend[g] + 1;
      end
      pulse  = (m_last[g] == cyc);
      active = (cyc - m_last[g] <= mg_of(g));
      busy_e = active || (m_pend[g] != 0);
      exp_q.push_back({pulse, busy_e, m_ovf[g], !active, 4'(m_pend[g])});
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observe(input int g);
    return {pulse_w[g], busy_w[g], ovf_w[g], state_w[g] == 2'd0, pend_w[g]};
  endfunction

  task automatic compare_all();
    logic [W-1:0] exp;
    for (int g = 0; g < N_DUT; g++) begin
      exp = exp_q.pop_front();
      check($sformatf("cyc%0d_dut%0d", cyc, g), observe(g), exp);
      if (pulse_w[g]) pulse_cnt[g]++;
    end
  endtask

  task automatic clear_counts();
    for (int g = 0; g < N_DUT; g++) pulse_cnt[g] = 0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic c);
    req = r;
    clr = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    req   = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b1;
    cyc   = 0;
    clear_counts();
    model_reset();

    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < N_DUT; g++) check($sformatf("reset_dut%0d", g), observe(g), 8'b0001_0000);
    #10 rst_n = 1'b1;

    // Single beat sampled at 25ns
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_int("t1_pulse_at_25ns", 32'(pulse_w[0]), 1);
    step(1'b0, 1'b0);
    check_int("t1_pulse_low_35ns", 32'(pulse_w[0]), 0);
    idle(8);

    // Three back-to-back beats
    clear_counts();
    repeat (3) step(1'b1, 1'b0);
    idle(10);
    check_int("t2_pulses_mg1", pulse_cnt[0], 3);
    check_int("t2_no_overflow", 32'(ovf_w[0]), 0);

    // Eight beats into a 2-bit backlog with MIN_GAP=3
    clear_counts();
    repeat (8) step(1'b1, 1'b0);
    idle(25);
    check_int("t3_pulses_mg3", pulse_cnt[1], 5);
    check_int("t3_ovf_sticky", 32'(ovf_w[1]), 1);
    check_int("t3_pend_drained", 32'(pend_w[1]), 0);

    // Clear during GAP with pending=2 and a simultaneous request
    repeat (3) step(1'b1, 1'b0);
    check_int("t4_pend_before_clear", 32'(pend_w[1]), 2);
    step(1'b1, 1'b1);
    check_int("t4_pend_cleared", 32'(pend_w[1]), 0);
    check_int("t4_ovf_cleared", 32'(ovf_w[1]), 0);
    clear_counts();
    idle(8);
    check_int("t4_no_more_pulses", pulse_cnt[1], 0);
    check_int("t4_back_to_idle", 32'(state_w[1] == 2'd0), 1);

    // Asynchronous reset in the middle of a pulse
    idle(40);
    req = 1'b1;
    @(posedge clk);
    model_edge(1'b1, 1'b0);
    #1;
    compare_all();
    check_int("t5_pulse_before_reset", 32'(pulse_w[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < N_DUT; g++) check($sformatf("t5_async_reset_dut%0d", g), observe(g), 8'b0001_0000);
    model_reset();
    @(negedge clk);
    #2;
    req   = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_int("t5_latency_after_reset", 32'(pulse_w[0]), 1);
    idle(12);

    // Random traffic with varying request density
    for (int blk = 0; blk < 10; blk++) begin
      int dens;
      dens = int'($urandom_range(5, 95));
      for (int i = 0; i < 1000; i++) begin
        step(int'($urandom_range(0, 99)) < dens, $urandom_range(0, 199) == 0);
      end
    end
    idle(100);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Source-side generator for single-cycle strobes: converts per-cycle request beats into a train of clean pulses on pulse_out.
- Every pulse is high for exactly one clock and is followed by at least MIN_GAP low cycles.
- Requests arriving faster than pulses can be emitted are queued in a saturating pending counter.
- Sits in front of any consumer that requires a strict one-cycle-pulse contract.

Parameters:
- MIN_GAP, default 1: number of low cycles forced after each pulse; legal range 1..255.
- CNT_W, default 4: width of the pending-request counter; maximum queued requests = 2^CNT_W-1.

Ports:
- clk, input, 1: sole clock; all logic on posedge.
- reset, input, 1: asynchronous, active-low reset.
- req_in, input, 1: each posedge sampling req_in=1 counts as one request; holding it high N cycles means N requests.
- clear, input, 1: synchronous flush of queued requests and overflow.
- pulse_out, output, 1: registered single-cycle strobe.
- pending, output, CNT_W: count of queued, not-yet-emitted requests.
- busy, output, 1: high when the state is not IDLE or pending != 0.
- overflow, output, 1: sticky flag; set when a request is dropped at saturation.

Behaviour:
- Reset (reset=0, asynchronous): pulse_out=0, pending=0, overflow=0, busy=0, state=IDLE. Assertion clears outputs immediately, including mid-pulse.
- States:
  - IDLE: pulse_out=0.
  - PULSE: pulse_out=1; lasts exactly one cycle.
  - GAP: pulse_out=0; lasts exactly MIN_GAP cycles, counted by gap_cnt.
- IDLE, at an edge with req_in=1: go to PULSE; the request is consumed directly and pending is unchanged. Latency is 1 cycle, so a request sampled at edge k gives pulse_out high from edge k to k+1.
- IDLE with pending!=0: not reachable.
- PULSE: always goes to GAP; gap_cnt is loaded with MIN_GAP-1. A req_in=1 in this state increments pending.
- GAP:
  - While gap_cnt!=0: decrement gap_cnt; req_in increments pending.
  - On the last GAP cycle, if pending!=0 or req_in=1: go to PULSE and consume one request. The result is pending-1 if req_in=0, or pending unchanged if req_in=1 (increment and consume cancel).
  - On the last GAP cycle otherwise: go to IDLE.
- Saturation: an increment with pending=2^CNT_W-1 and no same-cycle consume drops the request, keeps pending at max, and sets overflow=1. Overflow remains set until clear or reset.
- clear=1 at an edge:
  - pending becomes 0 and overflow becomes 0.
  - req_in in the same cycle is ignored.
  - The state machine is not aborted. PULSE still proceeds to GAP, GAP still completes, then the machine goes to IDLE. The gap rule is never violated.
- Invariants (enforced by bench SVA):
  - pulse_out is never high on two consecutive posedges.
  - After each pulse, pulse_out stays low for at least MIN_GAP posedges.
  - pending never wraps.
- Width rules:
  - gap_cnt is 8 bits.
  - pending is an unsigned CNT_W-bit value; there is no arithmetic beyond +1/-1.

Test Plan:
1. MIN_GAP=1: single req_in beat sampled at 25ns (10ns clock) -> pulse_out high for the 25-35ns cycle only, pending stays 0, busy drops after GAP.
2. MIN_GAP=1: req_in held for 3 consecutive edges -> pulses on alternate cycles (3 total), pending peaks at 1, then returns to 0, overflow=0.
3. MIN_GAP=3, CNT_W=2: req_in held for 8 edges -> pending saturates at 3, overflow=1, exactly 5 pulses each spaced 4 cycles apart, pending ends at 0, overflow stays 1.
4. With pending=2 in GAP, assert clear for one cycle together with req_in=1 -> pending=0 and overflow=0 next edge, GAP completes, state returns to IDLE, no further pulses.
5. Drive reset=0 asynchronously mid-PULSE (between edges) -> pulse_out, pending, busy and overflow go to 0 immediately. After release, a new req_in gives a pulse with 1-cycle latency.
6. Run the SVA "pulse_out |-> !$past(pulse_out)" plus a gap-length check across random req_in/clear traffic for 10k cycles with MIN_GAP in {1,2,5} -> zero assertion failures.
